// File: rtl/pipe_stage_reg_pkg.sv
// Shared pipeline definitions: stage occupancy encodings, default datapath width
// and the instruction field layout carried through the IF/ID/EX/MEM/WB stages.
package pipe_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_W   = 7;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_t;

endpackage

// File: rtl/pipe_data_reg.sv
// WIDTH-bit data register with asynchronous reset to RESET_VAL and a load enable.
module pipe_data_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DATA_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Payload storage, updated only when load is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid
// buffer and synchronous flush of all held entries.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH     = DATA_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic             valid_r;
  logic             rdy_r;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic             main_load_s;
  logic             main_from_skid_s;
  logic             skid_load_s;
  logic [WIDTH-1:0] main_d_s;
  logic [WIDTH-1:0] skid_q_s;

  // rdy_r is low through reset and low in TWO; without a skid entry the
  // downstream ready must pass straight through so a full stage can still refill.
  assign in_ready   = rdy_r & ~flush & (SKID ? 1'b1 : (~valid_r | out_ready));
  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = valid_r & out_ready;

  // Next-state and data-register load decode.
  always_comb begin
    state_nxt_s      = state_r;
    main_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            state_nxt_s = ST_ONE;
            main_load_s = 1'b1;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            state_nxt_s = ST_ONE;
            main_load_s = 1'b1;
          end else if (in_xfer_s) begin
            state_nxt_s = ST_TWO;
            skid_load_s = 1'b1;
          end else if (out_xfer_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_TWO: begin
          if (out_xfer_s) begin
            state_nxt_s      = ST_ONE;
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
          end else begin
            state_nxt_s = ST_TWO;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Control FSM with registered valid, occupancy and ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_EMPTY;
      valid_r <= 1'b0;
      rdy_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      valid_r <= (state_nxt_s != ST_EMPTY);
      rdy_r   <= (state_nxt_s != ST_TWO);
    end
  end

  assign main_d_s  = main_from_skid_s ? skid_q_s : in_data;
  assign out_valid = valid_r;
  assign occupancy = state_r;

  pipe_data_reg #(
    .WIDTH     (WIDTH),
    .RESET_VAL (RESET_VAL)
  ) u_main (
    .clk  (clk),
    .rst  (rst),
    .load (main_load_s),
    .d    (main_d_s),
    .q    (out_data)
  );

  generate
    if (SKID) begin : g_skid
      pipe_data_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
      ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (skid_load_s),
        .d    (in_data),
        .q    (skid_q_s)
      );
    end else begin : g_no_skid
      logic unused_skid_load_s;
      assign unused_skid_load_s = skid_load_s;
      assign skid_q_s           = RESET_VAL;
    end
  endgenerate

endmodule
